alu_onboard_console: RTL and testbench
======================================

// Module: alu_onboard_console
// PURPOSE
//  Parametrised board-level operand console for the adder/subtractor datapath.
//  Debounces two active-low buttons and enters multi-nibble operands from 4 switches.
//  Selects add/sub with button chords and pages the WIDTH-bit result onto 8 active-low LEDs.
//  Sits directly between board pins and LEDs; contains its own adder/subtractor.
// PARAMETERS
//  WIDTH            32      operand/result width; multiple of 4, >=8; NIB=WIDTH/4 pages
//  DEBOUNCE_CYCLES  250000  consecutive stable cycles before a button state is accepted
// PORTS
//  CLK       in   1  system clock
//  RST_N     in   1  synchronous active-low reset
//  SWITCH    in   4  nibble / chord code input
//  BUTTON_A  in   1  raw button, active-low, asynchronous to CLK
//  BUTTON_B  in   1  raw button, active-low, asynchronous to CLK
//  LED       out  8  status/result display, active-low (0 = lit)
// BEHAVIOUR
//  Reset (RST_N=0 at posedge CLK): valA=valB=0, sign=0, state=ENTRY, page=0, last=A,
//   result/flags=0, debounced buttons=released; LED=8'hFF. Reset mid-press: the press is discarded.
//  Input path: each button 2-FF synchronised; debounced level toggles only after the
//   synced level differs from it for DEBOUNCE_CYCLES consecutive cycles (counter restarts on any bounce).
//  Events (1-cycle pulses, derived from debounced levels):
//   - CHORD: both debounced pressed, issued on the cycle the second button becomes pressed.
//   - RELA/RELB: issued on debounced release of A/B, only if the other button was not
//     pressed at any time since this press began; any press that overlapped a chord emits nothing.
//  CHORD decode by SWITCH (both states): 0101 -> sign=0 (add); 1010 -> sign=1 (sub);
//   0000 -> valA=valB=0, page=0, state=ENTRY; 1111 -> toggle state ENTRY<->SHOW, page=0;
//   other codes: no effect.
//  ENTRY: RELA -> valA={valA[WIDTH-5:0],SWITCH}, last=A; RELB -> same into valB, last=B.
//   Top nibble shifts out; no saturation.
//  SHOW: RELA -> page=page+1 (NIB-1 wraps to 0); RELB -> page=page-1 (0 wraps to NIB-1).
//   Operands frozen in SHOW.
//  Arithmetic: {cout,res} = valA + (sign ? ~valB : valB) + sign, registered every cycle
//   (1-cycle latency after an operand/sign change). Sub cout=1 means no borrow.
//  LED (before inversion): [7]=sign; [6]=flag in SHOW, 0 in ENTRY; [5]=state (1=SHOW);
//   [4]=last (ENTRY, 1=B) or page[0] (SHOW); [3:0]=low nibble of last operand (ENTRY)
//   or res[4*page+3:4*page] (SHOW). LED is registered: 1 cycle after internal state.
// CONFIGURATION
//  SIGNED_OVF_EN defined: flag = two's-complement overflow of the add/sub
//   (operand signs equal, after B inversion for sub, and result sign differs).
//  SIGNED_OVF_EN undefined: flag = cout. No other behaviour changes.
// TESTING (WIDTH=16, DEBOUNCE_CYCLES=4)
//  Reset: RST_N=0 for 2 cycles -> LED=8'hFF; A pulse <4 cycles long -> no state change.
//  ENTRY: SWITCH=1,2,3,4 with a clean A press/release each -> valA=16'h1234,
//   LED=~8'h04. SWITCH=5 again -> valA=16'h2345.
//  Add: valA=16'hFFFF, valB=16'h0001, chord 0101 then chord 1111 -> SHOW,
//   page0 LED=~8'h60 (cout=1, nibble 0); undefined macro.
//  Sub/paging: valA=16'h0003, valB=16'h0005, chord 1010, 1111 -> res=16'hFFFE, cout=0;
//   B release from page0 -> page3, LED[3:0]=~4'hF; A release from page3 -> page0.
//  SIGNED_OVF_EN: valA=16'h7FFF + valB=16'h0001 -> LED[6] lit; undefined macro -> dark.
//  Chord isolation: press A, press B, SWITCH=0000, release both -> operands cleared,
//   no RELA/RELB shift; reset asserted during SHOW -> ENTRY, LED=8'hFF next cycle.

Source files
------------

// File: rtl/alu_onboard_console.sv
// alu_onboard_console
//   Board-level operand console around an adder/subtractor. Two raw active-low buttons are
//   synchronised and debounced. Clean single-button releases enter nibbles (ENTRY) or page
//   through the result (SHOW). Two-button chords pick add/sub, clear, or toggle ENTRY/SHOW.
//   The chord action is chosen by the code on SWITCH.
//
// Ports
//   CLK       in   1  system clock
//   RST_N     in   1  synchronous active-low reset
//   SWITCH    in   4  nibble / chord code
//   BUTTON_A  in   1  raw button A, active-low, asynchronous
//   BUTTON_B  in   1  raw button B, active-low, asynchronous
//   LED       out  8  active-low display {sign, flag, state, last/page[0], nibble}
//
// Build option
//   SIGNED_OVF_EN  when defined, the flag LED shows signed overflow instead of carry-out.

module alu_onboard_console #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] SWITCH,
  input  logic       BUTTON_A,
  input  logic       BUTTON_B,
  output logic [7:0] LED
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned PW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PageLast = PW'(NIB - 1);

  typedef enum logic {StEntry = 1'b0, StShow = 1'b1} state_e;

  // Button index 0 = A, 1 = B. Debounced levels are active-high (1 = pressed).
  logic [1:0]    r_meta, r_sync, r_db, r_db_prev, r_taint;
  logic [CW-1:0] r_cnt [2];

  logic [1:0] w_press, w_release;
  logic       w_chord, w_rel_a, w_rel_b;

  state_e            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_val_a, r_val_b, w_val_a_nxt, w_val_b_nxt;
  logic              r_sign, w_sign_nxt, r_last, w_last_nxt;
  logic [PW-1:0]     r_page, w_page_nxt;

  logic [WIDTH-1:0]  w_b_eff, r_res;
  logic [WIDTH:0]    w_sum;
  logic              w_flag_nxt, r_flag;
  logic [3:0]        w_nib;
  logic [7:0]        w_led_nxt, r_led;

  // Synchroniser, debouncer and per-press overlap tracking.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_meta    <= 2'b11;
      r_sync    <= 2'b11;
      r_db      <= 2'b00;
      r_db_prev <= 2'b00;
      r_taint   <= 2'b00;
      r_cnt[0]  <= '0;
      r_cnt[1]  <= '0;
    end else begin
      r_meta    <= {BUTTON_B, BUTTON_A};
      r_sync    <= r_meta;
      r_db_prev <= r_db;
      for (int i = 0; i < 2; i++) begin
        if (~r_sync[i] != r_db[i]) begin
          if (r_cnt[i] == CntLast) begin
            r_db[i]  <= ~r_db[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
      // A press is tainted once the other button has been seen pressed during it.
      if (w_press[0])   r_taint[0] <= r_db[1];
      else if (&r_db)   r_taint[0] <= 1'b1;
      if (w_press[1])   r_taint[1] <= r_db[0];
      else if (&r_db)   r_taint[1] <= 1'b1;
    end
  end

  assign w_press   = r_db & ~r_db_prev;
  assign w_release = ~r_db & r_db_prev;
  assign w_chord   = (&r_db) & ~(&r_db_prev);
  assign w_rel_a   = w_release[0] & ~r_taint[0];
  assign w_rel_b   = w_release[1] & ~r_taint[1];

  // Console FSM: next state, operands, sign and page.
  always_comb begin
    w_state_nxt = r_state;
    w_val_a_nxt = r_val_a;
    w_val_b_nxt = r_val_b;
    w_sign_nxt  = r_sign;
    w_last_nxt  = r_last;
    w_page_nxt  = r_page;
    if (w_chord) begin
      case (SWITCH)
        4'b0101: w_sign_nxt = 1'b0;
        4'b1010: w_sign_nxt = 1'b1;
        4'b0000: begin
          w_val_a_nxt = '0;
          w_val_b_nxt = '0;
          w_page_nxt  = '0;
          w_state_nxt = StEntry;
        end
        4'b1111: begin
          w_state_nxt = (r_state == StEntry) ? StShow : StEntry;
          w_page_nxt  = '0;
        end
        default: ;
      endcase
    end else if (r_state == StEntry) begin
      if (w_rel_a) begin
        w_val_a_nxt = {r_val_a[WIDTH-5:0], SWITCH};
        w_last_nxt  = 1'b0;
      end else if (w_rel_b) begin
        w_val_b_nxt = {r_val_b[WIDTH-5:0], SWITCH};
        w_last_nxt  = 1'b1;
      end
    end else begin
      if (w_rel_a) begin
        w_page_nxt = (r_page == PageLast) ? '0 : r_page + 1'b1;
      end else if (w_rel_b) begin
        w_page_nxt = (r_page == '0) ? PageLast : r_page - 1'b1;
      end
    end
  end

  // Subtraction is A + ~B + 1, so carry-out = 1 means no borrow.
  assign w_b_eff = r_sign ? ~r_val_b : r_val_b;
  assign w_sum   = {1'b0, r_val_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, r_sign};

`ifdef SIGNED_OVF_EN
  assign w_flag_nxt = (r_val_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != r_val_a[WIDTH-1]);
`else
  assign w_flag_nxt = w_sum[WIDTH];
`endif

  assign w_nib = (r_state == StShow) ? r_res[{r_page, 2'b00} +: 4]
               : (r_last ? r_val_b[3:0] : r_val_a[3:0]);

  assign w_led_nxt = ~{r_sign,
                       (r_state == StShow) & r_flag,
                       r_state == StShow,
                       (r_state == StShow) ? r_page[0] : r_last,
                       w_nib};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= StEntry;
      r_val_a <= '0;
      r_val_b <= '0;
      r_sign  <= 1'b0;
      r_last  <= 1'b0;
      r_page  <= '0;
      r_res   <= '0;
      r_flag  <= 1'b0;
      r_led   <= 8'hFF;
    end else begin
      r_state <= w_state_nxt;
      r_val_a <= w_val_a_nxt;
      r_val_b <= w_val_b_nxt;
      r_sign  <= w_sign_nxt;
      r_last  <= w_last_nxt;
      r_page  <= w_page_nxt;
      r_res   <= w_sum[WIDTH-1:0];
      r_flag  <= w_flag_nxt;
      r_led   <= w_led_nxt;
    end
  end

  assign LED = r_led;

endmodule

// File: tb/tb_alu_onboard_console.sv
// Testbench for alu_onboard_console at WIDTH=16, DEBOUNCE_CYCLES=4.
// A behavioural model (operands, sign, mode, page) predicts the LED byte from
// plain arithmetic; directed steps are followed by random clicks and chords.

module tb_alu_onboard_console;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] SWITCH = 4'h0;
  logic       BUTTON_A = 1'b1;
  logic       BUTTON_B = 1'b1;
  logic [7:0] LED;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_a, m_b;
  bit          m_sign, m_show, m_last;
  int          m_page;

  alu_onboard_console #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .SWITCH(SWITCH),
    .BUTTON_A(BUTTON_A),
    .BUTTON_B(BUTTON_B),
    .LED(LED)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] exp_led();
    logic [15:0] nb, res;
    int unsigned bx, sum;
    int          sa, sb, sr;
    bit          cout, ovf, flag;
    logic [3:0]  nib;
    logic        p0;
    nb   = ~m_b;
    bx   = m_sign ? nb : m_b;
    sum  = m_a + bx + m_sign;
    res  = sum[15:0];
    cout = sum[16];
    sa   = int'($signed(m_a));
    sb   = int'($signed(m_b));
    sr   = m_sign ? sa - sb : sa + sb;
    ovf  = (sr > 32767) || (sr < -32768);
`ifdef SIGNED_OVF_EN
    flag = ovf;
`else
    flag = cout;
`endif
    res  = res >> (4 * m_page);
    nib  = m_show ? res[3:0] : (m_last ? m_b[3:0] : m_a[3:0]);
    p0   = m_show ? m_page[0] : m_last;
    return ~{m_sign, m_show & flag, m_show, p0, nib};
  endfunction

  task automatic chk(input string tag);
    logic [7:0] e;
    e = exp_led();
    n_vec++;
    assert (LED === e) else begin
      n_err++;
      $error("FAIL %s: LED observed %h expected %h", tag, LED, e);
    end
  endtask

  task automatic chk_const(input string tag, input logic [7:0] e);
    n_vec++;
    assert (LED === e) else begin
      n_err++;
      $error("FAIL %s: LED observed %h expected %h", tag, LED, e);
    end
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_sign = 0; m_show = 0; m_last = 0; m_page = 0;
  endtask

  task automatic set_btn(input int which, input logic v);
    if (which == 0) BUTTON_A = v;
    else            BUTTON_B = v;
  endtask

  // Drive a button to lvl, optionally with short bounces first, then hold long enough to settle.
  task automatic drive(input int which, input logic lvl, input bit bounce);
    if (bounce) begin
      set_btn(which, lvl);  tick(2);
      set_btn(which, ~lvl); tick(1);
      set_btn(which, lvl);  tick(1);
      set_btn(which, ~lvl); tick(2);
    end
    set_btn(which, lvl);
    tick(12);
  endtask

  task automatic click(input int which, input logic [3:0] sw, input bit bounce, input string tag);
    SWITCH = sw;
    drive(which, 1'b0, bounce);
    drive(which, 1'b1, bounce);
    if (!m_show) begin
      if (which == 0) begin m_a = {m_a[11:0], sw}; m_last = 0; end
      else            begin m_b = {m_b[11:0], sw}; m_last = 1; end
    end else begin
      m_page = (which == 0) ? (m_page + 1) % 4 : (m_page + 3) % 4;
    end
    chk(tag);
  endtask

  task automatic chord(input logic [3:0] code, input int first, input bit simul,
                       input int rel_first, input string tag);
    SWITCH = code;
    if (simul) begin
      BUTTON_A = 1'b0; BUTTON_B = 1'b0; tick(12);
    end else begin
      drive(first, 1'b0, 0);
      drive(1 - first, 1'b0, 0);
    end
    drive(rel_first, 1'b1, 0);
    drive(1 - rel_first, 1'b1, 0);
    case (code)
      4'b0101: m_sign = 0;
      4'b1010: m_sign = 1;
      4'b0000: begin m_a = '0; m_b = '0; m_page = 0; m_show = 0; end
      4'b1111: begin m_show = !m_show; m_page = 0; end
      default: ;
    endcase
    chk(tag);
  endtask

  task automatic enter16(input int which, input logic [15:0] v);
    for (int i = 3; i >= 0; i--) click(which, v[4*i +: 4], 0, "enter");
  endtask

  initial begin
    model_reset();
    // Reset
    RST_N = 1'b0; tick(2);
    chk_const("reset_led", 8'hFF);
    chk("reset_model");
    RST_N = 1'b1; tick(1);

    // Short A pulse is filtered out
    SWITCH = 4'h9;
    BUTTON_A = 1'b0; tick(3); BUTTON_A = 1'b1; tick(12);
    chk("short_pulse");

    // Nibble entry
    click(0, 4'h1, 0, "entry1");
    click(0, 4'h2, 1, "entry2");
    click(0, 4'h3, 0, "entry3");
    click(0, 4'h4, 1, "entry4");
    chk_const("entry_1234", ~8'h04);
    click(0, 4'h5, 0, "entry5");
    chk_const("entry_2345", ~8'h05);

    // Add with carry out
    chord(4'h0, 0, 0, 0, "clear");
    enter16(0, 16'hFFFF);
    enter16(1, 16'h0001);
    chord(4'b0101, 1, 0, 1, "add_sel");
    chord(4'b1111, 0, 0, 1, "to_show");
`ifndef SIGNED_OVF_EN
    chk_const("add_page0", ~8'h60);
`endif

    // Subtract and paging
    chord(4'b1111, 0, 1, 0, "to_entry");
    chord(4'h0, 1, 0, 0, "clear2");
    click(0, 4'h3, 0, "a3");
    click(1, 4'h5, 0, "b5");
    chord(4'b1010, 0, 0, 0, "sub_sel");
    chord(4'b1111, 1, 0, 1, "to_show2");
    click(1, 4'h0, 0, "page_dec_wrap");
    chk_const("sub_page3_nib", {LED[7:4], ~4'hF});
    click(0, 4'h0, 0, "page_inc_wrap");
`ifndef SIGNED_OVF_EN
    chk_const("sub_page0", ~8'hAE);
`endif

    // Signed overflow case
    chord(4'h0, 0, 0, 1, "clear3");
    enter16(0, 16'h7FFF);
    click(1, 4'h1, 0, "b1");
    chord(4'b0101, 0, 0, 0, "add_sel2");
    chord(4'b1111, 0, 0, 0, "to_show3");
`ifdef SIGNED_OVF_EN
    chk_const("ovf_lit", ~8'h60);
`else
    chk_const("ovf_dark", ~8'h20);
`endif

    // Reset during SHOW
    RST_N = 1'b0; tick(1);
    chk_const("reset_in_show", 8'hFF);
    RST_N = 1'b1; model_reset(); tick(1);
    chk("after_reset");

    // Reset mid-press, released while in reset
    SWITCH = 4'h7;
    BUTTON_A = 1'b0; tick(12);
    RST_N = 1'b0; tick(1);
    BUTTON_A = 1'b1; tick(3);
    RST_N = 1'b1; tick(14);
    chk("reset_mid_press");

    // Random clicks and chords
    for (int k = 0; k < 40; k++) begin
      int op;
      op = $urandom_range(0, 5);
      if (op < 4) begin
        click(op % 2, 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), "rnd_click");
      end else begin
        logic [3:0] code;
        case ($urandom_range(0, 5))
          0:       code = 4'b0101;
          1:       code = 4'b1010;
          2:       code = 4'b0000;
          3, 4:    code = 4'b1111;
          default: code = 4'($urandom_range(0, 15));
        endcase
        chord(code, $urandom_range(0, 1), bit'($urandom_range(0, 3) == 0),
              $urandom_range(0, 1), "rnd_chord");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
